// File: rtl/fpm_dram_pkg.sv
// Shared types and default timing for the fast-page-mode DRAM controller.
// The optional periodic refresh is enabled by defining FPM_DRAM_REFRESH_EN.
package fpm_dram_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_REF,
    IDLE,
    REF,
    ROW,
    RCD,
    COL,
    CAS,
    CP,
    PRE
  } state_t;

  typedef enum logic [1:0] {
    CBR_CAS,
    CBR_RAS,
    CBR_PRE
  } cbr_ph_t;

  localparam int DEF_ROW_BITS       = 8;
  localparam int DEF_COL_BITS       = 8;
  localparam int DEF_DQ_W           = 4;
  localparam int DEF_BEATS          = 2;
  localparam int DEF_INIT_CYCLES    = 10000;
  localparam int DEF_INIT_REFRESHES = 8;
  localparam int DEF_REFRESH_CYCLES = 781;
  localparam int DEF_T_RCD          = 2;
  localparam int DEF_T_CAS          = 3;
  localparam int DEF_T_CP           = 1;
  localparam int DEF_T_RP           = 5;

  localparam int CBR_CAS_CYC = 2;
  localparam int CBR_RAS_CYC = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fpm_dram_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared by every stall state of the controller.
module fpm_dram_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/fpm_dram_ctrl.sv
// Fast-page-mode DRAM controller: init pause, CBR refresh, BEATS-beat words.
// Define FPM_DRAM_REFRESH_EN to enable init and periodic CBR refresh.
module fpm_dram_ctrl
  import fpm_dram_pkg::*;
#(
  parameter int ROW_BITS       = DEF_ROW_BITS,
  parameter int COL_BITS       = DEF_COL_BITS,
  parameter int DQ_W           = DEF_DQ_W,
  parameter int BEATS          = DEF_BEATS,
  parameter int INIT_CYCLES    = DEF_INIT_CYCLES,
  parameter int INIT_REFRESHES = DEF_INIT_REFRESHES,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int T_RCD          = DEF_T_RCD,
  parameter int T_CAS          = DEF_T_CAS,
  parameter int T_CP           = DEF_T_CP,
  parameter int T_RP           = DEF_T_RP,
  localparam int W  = DQ_W * BEATS,
  localparam int AW = max2(ROW_BITS, COL_BITS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
  input  logic [W-1:0]                 req_wdata,
  output logic                         rsp_valid,
  output logic [W-1:0]                 rsp_rdata,
  output logic                         busy,
  output logic [AW-1:0]                ram_addr,
  output logic [DQ_W-1:0]              ram_dq_o,
  output logic                         ram_dq_oe,
  input  logic [DQ_W-1:0]              ram_dq_i,
  output logic                         ram_ras_,
  output logic                         ram_cas_,
  output logic                         ram_we_,
  output logic                         ram_oe_
);

  localparam int TW  = $clog2(max2(max2(INIT_CYCLES, REFRESH_CYCLES),
                                   max2(T_RP, 8)) + 1);
  localparam int BTW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW = $clog2(INIT_REFRESHES + 1);
  localparam int IW0 = (INIT_CYCLES > 1) ? INIT_CYCLES - 2 : 0;

  state_t                state;
  cbr_ph_t               ph;
  logic                  armed;
  logic [RCW-1:0]        ref_cnt;
  logic [ROW_BITS-1:0]   row_q;
  logic [COL_BITS-1:0]   col_q;
  logic                  wr_q;
  logic [W-1:0]          wdata_q;
  logic [W-1:0]          rbuf;
  logic [BTW-1:0]        beat;
  logic [COL_BITS-1:0]   col_cur;
  logic [ROW_BITS-1:0]   req_row;
  logic [COL_BITS-1:0]   req_col;
  logic                  last_beat;
  logic                  last_ref;
  logic                  ld;
  logic [TW-1:0]         ld_val;
  logic                  done;

  assign req_row   = req_addr[ROW_BITS+COL_BITS-1:COL_BITS];
  assign req_col   = req_addr[COL_BITS-1:0];
  assign col_cur   = col_q + COL_BITS'(beat);
  assign last_beat = (beat == BTW'(BEATS - 1));
  assign last_ref  = (ref_cnt == RCW'(INIT_REFRESHES - 1));
  assign busy      = (state != IDLE);

`ifdef FPM_DRAM_REFRESH_EN
  logic [TW-1:0] rtmr;
  logic          refresh_due;

  assign refresh_due = (rtmr >= TW'(REFRESH_CYCLES));
  assign req_ready   = (state == IDLE) && !refresh_due;

  // saturates at the threshold so it can never wrap past it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtmr <= '0;
    end else if (state == IDLE && refresh_due) begin
      rtmr <= '0;
    end else if (state != INIT_WAIT && !refresh_due) begin
      rtmr <= rtmr + 1'b1;
    end
  end
`else
  assign req_ready = (state == IDLE);
`endif

  fpm_dram_timer #(
    .W(TW)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .done     (done)
  );

  // timer is loaded on the cycle that enters a timed state
  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    unique case (state)
      INIT_WAIT: begin
        if (!armed) begin
          ld     = 1'b1;
          ld_val = TW'(IW0);
        end
`ifdef FPM_DRAM_REFRESH_EN
        else if (done) begin
          ld     = 1'b1;
          ld_val = TW'(CBR_CAS_CYC - 1);
        end
`endif
      end
      INIT_REF, REF: begin
        if (done) begin
          ld = 1'b1;
          unique case (ph)
            CBR_CAS: ld_val = TW'(CBR_RAS_CYC - 1);
            CBR_RAS: ld_val = TW'(T_RP - 1);
            default: ld_val = TW'(CBR_CAS_CYC - 1);
          endcase
        end
      end
`ifdef FPM_DRAM_REFRESH_EN
      IDLE: begin
        if (refresh_due) begin
          ld     = 1'b1;
          ld_val = TW'(CBR_CAS_CYC - 1);
        end
      end
`endif
      ROW: begin
        ld     = 1'b1;
        ld_val = TW'(T_RCD - 1);
      end
      COL: begin
        ld     = 1'b1;
        ld_val = TW'(T_CAS - 1);
      end
      CAS: begin
        if (done) begin
          ld     = 1'b1;
          ld_val = last_beat ? TW'(T_RP - 1) : TW'(T_CP - 1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_WAIT;
      ph        <= CBR_CAS;
      armed     <= 1'b0;
      ref_cnt   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rbuf      <= '0;
      beat      <= '0;
      ram_addr  <= '0;
      ram_dq_o  <= '0;
      ram_dq_oe <= 1'b0;
      ram_ras_  <= 1'b1;
      ram_cas_  <= 1'b1;
      ram_we_   <= 1'b1;
      ram_oe_   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        INIT_WAIT: begin
          armed <= 1'b1;
          if (armed && done) begin
`ifdef FPM_DRAM_REFRESH_EN
            state    <= INIT_REF;
            ph       <= CBR_CAS;
            ram_cas_ <= 1'b0;
`else
            state    <= IDLE;
`endif
          end
        end
        INIT_REF, REF: begin
          if (done) begin
            unique case (ph)
              CBR_CAS: begin
                ph       <= CBR_RAS;
                ram_ras_ <= 1'b0;
              end
              CBR_RAS: begin
                ph       <= CBR_PRE;
                ram_ras_ <= 1'b1;
                ram_cas_ <= 1'b1;
              end
              default: begin
                if (state == INIT_REF && !last_ref) begin
                  ref_cnt  <= ref_cnt + 1'b1;
                  ph       <= CBR_CAS;
                  ram_cas_ <= 1'b0;
                end else begin
                  ref_cnt <= '0;
                  state   <= IDLE;
                end
              end
            endcase
          end
        end
        IDLE: begin
`ifdef FPM_DRAM_REFRESH_EN
          if (refresh_due) begin
            state    <= REF;
            ph       <= CBR_CAS;
            ram_cas_ <= 1'b0;
          end else
`endif
          if (req_valid && req_ready) begin
            row_q    <= req_row;
            col_q    <= req_col;
            wr_q     <= req_write;
            wdata_q  <= req_wdata;
            beat     <= '0;
            ram_addr <= AW'(req_row);
            ram_we_  <= !req_write;
            state    <= ROW;
          end
        end
        ROW: begin
          ram_ras_ <= 1'b0;
          state    <= RCD;
        end
        RCD: begin
          if (done) begin
            ram_addr <= AW'(col_cur);
            if (wr_q) begin
              ram_dq_oe <= 1'b1;
              ram_dq_o  <= wdata_q[int'(beat)*DQ_W +: DQ_W];
            end
            state <= COL;
          end
        end
        COL: begin
          ram_cas_ <= 1'b0;
          ram_oe_  <= wr_q;
          state    <= CAS;
        end
        CAS: begin
          if (done) begin
            ram_cas_  <= 1'b1;
            ram_oe_   <= 1'b1;
            ram_dq_oe <= 1'b0;
            if (!wr_q) begin
              rbuf[int'(beat)*DQ_W +: DQ_W] <= ram_dq_i;
            end
            if (last_beat) begin
              ram_ras_ <= 1'b1;
              state    <= PRE;
            end else begin
              beat  <= beat + 1'b1;
              state <= CP;
            end
          end
        end
        CP: begin
          if (done) begin
            ram_addr <= AW'(col_cur);
            if (wr_q) begin
              ram_dq_oe <= 1'b1;
              ram_dq_o  <= wdata_q[int'(beat)*DQ_W +: DQ_W];
            end
            state <= COL;
          end
        end
        PRE: begin
          if (done) begin
            ram_we_ <= 1'b1;
            state   <= IDLE;
            if (!wr_q) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rbuf;
            end
          end
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_dram_ctrl.sv
// Bench for fpm_dram_ctrl: pin-level DRAM model plus word-level scoreboard.
// Works with or without FPM_DRAM_REFRESH_EN.
module tb_fpm_dram_ctrl;

  localparam int RB   = 8;
  localparam int CB   = 8;
  localparam int DQ   = 4;
  localparam int BT   = 2;
  localparam int W    = DQ * BT;
  localparam int IC   = 10;
  localparam int IR   = 8;
  localparam int RC   = 200;
  localparam int TRCD = 2;
  localparam int TCAS = 3;
  localparam int TCP  = 1;
  localparam int TRP  = 5;
  localparam int LAT  = 1 + TRCD + BT*(1+TCAS) + (BT-1)*TCP + TRP;
  localparam int CBR_LEN = 2 + 5 + TRP;
`ifdef FPM_DRAM_REFRESH_EN
  localparam int INIT_LEN = IC + IR*CBR_LEN;
  localparam int INIT_CBR = IR;
`else
  localparam int INIT_LEN = IC;
  localparam int INIT_CBR = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [15:0]   req_addr;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic [W-1:0]  rsp_rdata;
  logic          busy;
  logic [7:0]    ram_addr;
  logic [DQ-1:0] ram_dq_o;
  logic          ram_dq_oe;
  logic [DQ-1:0] ram_dq_i;
  logic          ram_ras_;
  logic          ram_cas_;
  logic          ram_we_;
  logic          ram_oe_;

  fpm_dram_ctrl #(
    .ROW_BITS(RB), .COL_BITS(CB), .DQ_W(DQ), .BEATS(BT),
    .INIT_CYCLES(IC), .INIT_REFRESHES(IR), .REFRESH_CYCLES(RC),
    .T_RCD(TRCD), .T_CAS(TCAS), .T_CP(TCP), .T_RP(TRP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe),
    .ram_dq_i(ram_dq_i), .ram_ras_(ram_ras_), .ram_cas_(ram_cas_),
    .ram_we_(ram_we_), .ram_oe_(ram_oe_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // pin-level DRAM: row on RAS fall, column (and early write) on CAS fall
  logic [DQ-1:0] dram [0:65535];
  logic [7:0]    row_l = '0;
  logic [7:0]    col_l = '0;
  int            cbr_cnt = 0;
  int            col_log[$];
  int            row_log[$];

  always @(negedge ram_ras_) begin
    row_l = ram_addr;
    if (!ram_cas_) cbr_cnt++;
    else row_log.push_back(int'(ram_addr));
  end

  always @(negedge ram_cas_) begin
    if (!ram_ras_) begin
      col_l = ram_addr;
      col_log.push_back(int'(ram_addr));
      if (!ram_we_) dram[{row_l, col_l}] = ram_dq_o;
    end
  end

  assign ram_dq_i = (!ram_cas_ && !ram_oe_ && !ram_ras_) ?
                    dram[{row_l, col_l}] : '0;

  // word-level reference: beat b lives at column (col+b) mod 256, same row
  logic [DQ-1:0] model [0:65535];

  task automatic model_write(input logic [15:0] a, input logic [W-1:0] d);
    logic [7:0] c;
    for (int b = 0; b < BT; b++) begin
      c = a[7:0] + 8'(b);
      model[{a[15:8], c}] = d[b*DQ +: DQ];
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [15:0] a);
    logic [W-1:0] r;
    logic [7:0]   c;
    r = '0;
    for (int b = 0; b < BT; b++) begin
      c = a[7:0] + 8'(b);
      r[b*DQ +: DQ] = model[{a[15:8], c}];
    end
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } exp_t;

  exp_t         expq[$];
  exp_t         e_cur;
  int           rsp_seen = 0;
  int           last_lat = -1;
  logic [W-1:0] last_exp = '0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_seen++;
      if (expq.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e_cur = expq.pop_front();
        last_lat = cyc - e_cur.acc;
        chk("rsp_rdata", rsp_rdata, e_cur.data);
        chk("rsp_latency", last_lat, LAT);
      end
    end
  end

  // called on a falling edge; returns on a falling edge once idle again
  task automatic access(input logic wr, input logic [15:0] a,
                        input logic [W-1:0] d, input bit ref_first);
    int  n;
    bit  ok;
    int  c1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    c1 = cbr_cnt;
    if (ref_first) chk("ready_low_on_due", req_ready, 0);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 1000) begin
      if (req_ready) begin
        ok = 1'b1;
        if (ref_first) chk("refresh_before_accept", cbr_cnt - c1, 1);
        if (wr) model_write(a, d);
        else begin
          last_exp = model_read(a);
          expq.push_back('{data: last_exp, acc: cyc + 1});
        end
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_init(input string nm);
    int t0;
    int n;
    t0 = cyc;
    n  = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, cyc - t0, INIT_LEN);
  endtask

  typedef struct {
    logic [15:0]  a;
    logic [W-1:0] d;
  } vec_t;

  vec_t wr_tab[4];
  logic [15:0] rd_tab[6];
  int c0;
  int n;
  int ecbr;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dram[i]  = '0;
      model[i] = '0;
    end
    wr_tab[0] = '{16'h0000, 8'h3C};
    wr_tab[1] = '{16'hFFFF, 8'h96};
    wr_tab[2] = '{16'h5A01, 8'hF0};
    wr_tab[3] = '{16'h12FF, 8'h7E};
    rd_tab[0] = 16'h0000;
    rd_tab[1] = 16'hFFFF;
    rd_tab[2] = 16'h5A01;
    rd_tab[3] = 16'h12FF;
    rd_tab[4] = 16'h1200;
    rd_tab[5] = 16'h1233;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ras", ram_ras_, 1);
    chk("rst_cas", ram_cas_, 1);
    chk("rst_we", ram_we_, 1);
    chk("rst_oe", ram_oe_, 1);
    chk("rst_dq_oe", ram_dq_oe, 0);
    chk("rst_addr", ram_addr, 0);

    rst_n = 1'b1;
    wait_init("init_len");
    chk("init_cbr_count", cbr_cnt, INIT_CBR);
    chk("ready_in_idle", req_ready, 1);

    access(1'b1, 16'h1234, 8'hA5, 1'b0);
    access(1'b0, 16'h1234, '0, 1'b0);
    chk("read_1234_literal", rsp_rdata, 8'hA5);
    chk("latency_literal", last_lat, 17);

    for (int i = 0; i < 4; i++) begin
      col_log.delete();
      row_log.delete();
      access(1'b1, wr_tab[i].a, wr_tab[i].d, 1'b0);
      if (wr_tab[i].a == 16'h12FF) begin
        chk("wrap_beats", col_log.size(), 2);
        chk("wrap_col0", col_log[0], 8'hFF);
        chk("wrap_col1", col_log[1], 8'h00);
        chk("wrap_row", row_log[0], 8'h12);
      end
    end
    for (int i = 0; i < 6; i++) access(1'b0, rd_tab[i], '0, 1'b0);
    chk("read_1233_literal", rsp_rdata, 8'h50);

    access(1'b1, 16'h4242, 8'h11, 1'b0);
    chk("rdata_held_over_write", rsp_rdata, last_exp);

`ifdef FPM_DRAM_REFRESH_EN
    n = 0;
    while (!ram_cas_ && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!(!ram_cas_ && ram_ras_) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("refresh_seen_timeout", 0, 1);
    ecbr = cyc;
    while (cyc < ecbr + RC) @(negedge clk);
    access(1'b0, 16'h5A01, '0, 1'b1);
`endif

    // reset in the middle of a read's CAS-low window
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h1234;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(!ram_cas_ && !ram_ras_) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("cas_low_timeout", 0, 1);
    c0 = rsp_seen;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ras", ram_ras_, 1);
    chk("abort_cas", ram_cas_, 1);
    chk("abort_oe", ram_oe_, 1);
    chk("abort_we", ram_we_, 1);
    chk("abort_dq_oe", ram_dq_oe, 0);
    chk("abort_busy", busy, 1);
    repeat (2) @(negedge clk);
    c0 = rsp_seen;
    ecbr = cbr_cnt;
    rst_n = 1'b1;
    wait_init("reinit_len");
    chk("abort_no_rsp", rsp_seen - c0, 0);
    chk("reinit_cbr_count", cbr_cnt - ecbr, INIT_CBR);
    chk("reinit_rdata", rsp_rdata, 0);
    access(1'b0, 16'h1234, '0, 1'b0);
    chk("read_after_reinit", rsp_rdata, 8'hA5);

`ifndef FPM_DRAM_REFRESH_EN
    c0 = cbr_cnt;
    repeat (5000) @(negedge clk);
    chk("no_cbr_when_idle", cbr_cnt - c0, 0);
    chk("idle_not_busy", busy, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
